// File: rtl/max_pool_sequencer_pkg.sv
// max_pool_sequencer_pkg: shared default widths and controller state encoding
package max_pool_sequencer_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DIM_W  = 6;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAP, S_EMIT, S_FIN} state_t;
endpackage

// File: rtl/pool_max4.sv
// pool_max4: combinational two's-complement maximum of four samples
module pool_max4
    import max_pool_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    input  logic signed [DATA_W-1:0] i_c,
    input  logic signed [DATA_W-1:0] i_d,
    output logic signed [DATA_W-1:0] o_max
);
    logic signed [DATA_W-1:0] w_ab;
    logic signed [DATA_W-1:0] w_cd;
    assign w_ab  = (i_a > i_b) ? i_a : i_b;
    assign w_cd  = (i_c > i_d) ? i_c : i_d;
    assign o_max = (w_ab > w_cd) ? w_ab : w_cd;
endmodule

// File: rtl/max_pool_sequencer.sv
// max_pool_sequencer: walks a feature map in 2x2 windows, reads each window and emits its signed max
module max_pool_sequencer
    import max_pool_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = DEF_DIM_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic        [DIM_W-1:0]  cfg_w,
    input  logic        [DIM_W-1:0]  cfg_h,
    output logic                     rd_en,
    output logic        [ADDR_W-1:0] rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic        [ADDR_W-1:0] out_idx,
    output logic                     busy,
    output logic                     done
);
    state_t                   r_state;
    state_t                   w_next;
    logic        [1:0]        r_k;
    logic        [DIM_W-1:0]  r_w;
    logic        [DIM_W-1:0]  r_h;
    logic        [DIM_W-1:0]  r_r;
    logic        [DIM_W-1:0]  r_c;
    logic        [ADDR_W-1:0] r_base;
    logic        [ADDR_W-1:0] r_row;
    logic signed [DATA_W-1:0] r_d0;
    logic signed [DATA_W-1:0] r_d1;
    logic signed [DATA_W-1:0] r_d2;
    logic signed [DATA_W-1:0] w_max;
    logic        [ADDR_W-1:0] w_w;
    logic                     w_small;
    logic                     w_last_c;
    logic                     w_last_r;
    logic                     w_hs;

    assign w_w      = ADDR_W'(r_w);
    assign w_small  = (cfg_w < DIM_W'(2)) || (cfg_h < DIM_W'(2));
    assign w_last_c = r_c == (r_w >> 1) - DIM_W'(1);
    assign w_last_r = r_r == (r_h >> 1) - DIM_W'(1);
    assign w_hs     = (r_state == S_EMIT) && out_ready;
    assign rd_en    = r_state == S_FETCH;
    assign rd_addr  = rd_en ? r_base + (r_k[1] ? w_w : '0) + ADDR_W'(r_k[0]) : '0;
    assign busy     = r_state != S_IDLE;
    assign done     = (r_state == S_FIN) && !abort;

    pool_max4 #(.DATA_W(DATA_W)) u_max (
        .i_a  (r_d0),
        .i_b  (r_d1),
        .i_c  (r_d2),
        .i_d  (rd_data),
        .o_max(w_max)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // next-state: abort wins over everything outside IDLE
    always_comb begin
        w_next = r_state;
        if (abort && r_state != S_IDLE) w_next = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:  if (start) w_next = w_small ? S_FIN : S_FETCH;
                S_FETCH: if (r_k == 2'd3) w_next = S_CAP;
                S_CAP:   w_next = S_EMIT;
                S_EMIT:  if (out_ready) w_next = (w_last_c && w_last_r) ? S_FIN : S_FETCH;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // datapath: config latch, sample capture, result register and window walk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k       <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_r       <= '0;
            r_c       <= '0;
            r_base    <= '0;
            r_row     <= '0;
            r_d0      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else if (r_state == S_IDLE) begin
            r_k       <= '0;
            out_valid <= 1'b0;
            if (start) begin
                r_w     <= cfg_w;
                r_h     <= cfg_h;
                r_r     <= '0;
                r_c     <= '0;
                r_base  <= '0;
                r_row   <= '0;
                out_idx <= '0;
            end
        end else if (abort) begin
            r_k       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (r_state == S_FETCH) begin
                r_k <= r_k + 2'd1;
                if (r_k == 2'd1) r_d0 <= rd_data;
                if (r_k == 2'd2) r_d1 <= rd_data;
                if (r_k == 2'd3) r_d2 <= rd_data;
            end
            if (r_state == S_CAP) begin
                out_data  <= w_max;
                out_valid <= 1'b1;
            end
            if (w_hs) begin
                out_valid <= 1'b0;
                out_idx   <= out_idx + ADDR_W'(1);
                if (w_last_c) begin
                    r_c    <= '0;
                    r_r    <= r_r + DIM_W'(1);
                    r_row  <= r_row + (w_w << 1);
                    r_base <= r_row + (w_w << 1);
                end else begin
                    r_c    <= r_c + DIM_W'(1);
                    r_base <= r_base + ADDR_W'(2);
                end
            end
        end
    end
endmodule

// File: tb/tb_max_pool_sequencer.sv
// tb_max_pool_sequencer: directed scenarios checked against a window-level reference model
module tb_max_pool_sequencer;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               out_ready = 1'b1;
    logic        [5:0]  cfg_w = '0;
    logic        [5:0]  cfg_h = '0;
    logic               rd_en;
    logic        [9:0]  rd_addr;
    logic signed [15:0] rd_data = '0;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic        [9:0]  out_idx;
    logic               busy;
    logic               done;

    logic signed [15:0] mem [1024];
    int exp_addr[$];
    int exp_data[$];
    int exp_idx[$];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int first_rd = -1;
    int first_ov = -1;
    int n_done = 0;
    int n_out = 0;
    bit chk_en = 1'b0;

    max_pool_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_w(cfg_w), .cfg_h(cfg_h),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(string nm, logic signed [63:0] got, logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: every window's four addresses in order, and its signed max
    task automatic build(int w, int h);
        exp_addr.delete();
        exp_data.delete();
        exp_idx.delete();
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                int b;
                int m;
                int a[4];
                b = 2 * r * w + 2 * c;
                a = '{b, b + 1, b + w, b + w + 1};
                m = -100000;
                for (int k = 0; k < 4; k++) begin
                    a[k] = a[k] % 1024;
                    exp_addr.push_back(a[k]);
                    if (int'(mem[a[k]]) > m) m = int'(mem[a[k]]);
                end
                exp_data.push_back(m);
                exp_idx.push_back(exp_idx.size());
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (exp_addr.size() == 0) chk("rd_unexpected", rd_addr, -1);
                else chk("rd_addr", rd_addr, exp_addr.pop_front());
            end
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (exp_data.size() == 0) chk("out_unexpected", out_idx, -1);
                else begin
                    chk("out_data", out_data, exp_data[0]);
                    chk("out_idx", out_idx, exp_idx[0]);
                    if (out_ready) begin
                        void'(exp_data.pop_front());
                        void'(exp_idx.pop_front());
                        n_out++;
                    end
                end
            end
            if (done) n_done++;
        end
    end

    task automatic go(int w, int h);
        build(w, h);
        first_rd = -1;
        first_ov = -1;
        n_done = 0;
        n_out = 0;
        chk_en = 1'b1;
        cfg_w = 6'(w);
        cfg_h = 6'(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_w = 6'd0;
        cfg_h = 6'd0;
    endtask

    task automatic finish_pass(int stall);
        int left;
        bit seen;
        left = stall;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); #1;
            if (out_valid && left > 0) begin
                chk("stall_no_rd", rd_en, 0);
                left--;
                if (left == 0) out_ready = 1'b1;
            end
            if (done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        @(posedge clk); #1;
        chk("done_once", n_done, 1);
        chk("idle_after", busy, 0);
        chk("outs_left", exp_data.size(), 0);
        chk("reads_left", exp_addr.size(), 0);
        chk_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37 - 500);
        @(posedge clk); #2;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 4x4 ramp, always ready
        for (int i = 0; i < 16; i++) mem[i] = 16'(i);
        go(4, 4);
        chk("model44_0", exp_data[0], 5);
        chk("model44_1", exp_data[1], 7);
        chk("model44_2", exp_data[2], 13);
        chk("model44_3", exp_data[3], 15);
        finish_pass(0);
        chk("n_out_44", n_out, 4);
        chk("latency", first_ov - first_rd, 5);

        // 2x2 all-negative window
        mem[0] = -16'sd3; mem[1] = -16'sd1; mem[2] = -16'sd7; mem[3] = -16'sd2;
        go(2, 2);
        chk("model22", exp_data[0], -1);
        finish_pass(0);
        chk("n_out_22", n_out, 1);

        // 5x3: odd width and height drop last column and row
        for (int i = 0; i < 15; i++) mem[i] = 16'((i * 29) % 31 - 15);
        go(5, 3);
        chk("model53_n", exp_data.size(), 2);
        finish_pass(0);
        chk("n_out_53", n_out, 2);

        // 4x4 with 10-cycle stall on the first result
        for (int i = 0; i < 16; i++) mem[i] = 16'(100 - i * 9);
        out_ready = 1'b0;
        go(4, 4);
        finish_pass(10);
        chk("n_out_stall", n_out, 4);

        // abort during cycle 2 of the second window's fetch
        for (int i = 0; i < 16; i++) mem[i] = 16'(i);
        out_ready = 1'b1;
        go(4, 4);
        cnt = int'(rd_en);
        for (int i = 0; i < 200 && cnt < 6; i++) begin
            @(posedge clk); #1;
            if (rd_en) cnt++;
        end
        chk("abort_reached", cnt, 6);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("abort_no_done", n_done, 0);
        chk("abort_n_out", n_out, 1);
        chk_en = 1'b0;
        go(4, 4);
        finish_pass(0);
        chk("restart_n_out", n_out, 4);

        // reset during EMIT clears outputs asynchronously
        out_ready = 1'b0;
        go(4, 4);
        cnt = 0;
        for (int i = 0; i < 50 && !out_valid; i++) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("emit_reached", out_valid, 1);
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", out_data, 0);
        chk("arst_idx", out_idx, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 0);
        chk("post_rst_rd", rd_en, 0);

        // degenerate width: no reads, done on the next cycle
        build(1, 4);
        chk_en = 1'b1;
        n_done = 0;
        cfg_w = 6'd1;
        cfg_h = 6'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("small_done", done, 1);
        chk("small_rd", rd_en, 0);
        @(posedge clk); #1;
        chk("small_done_end", done, 0);
        chk("small_idle", busy, 0);
        chk("small_done_cnt", n_done, 1);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
